// File: rtl/signature_dumper_if.sv
// Memory read port and signature stream between the dumper and its environment.
// master = dumper side, slave = memory/bench side.
interface signature_dumper_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output mem_re,
    output mem_raddr,
    input  mem_rdata,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  mem_re,
    input  mem_raddr,
    output mem_rdata,
    input  out_valid,
    output out_data,
    output out_ready
  );
endinterface

// File: rtl/signature_dumper.sv
// End-of-run signature dumper: halts core on tohost write, streams signature.
// Optional IDLE watchdog enabled by defining SIG_TIMEOUT_EN.
module signature_dumper #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned       TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                snoop_we,
  input  logic [ADDR_W-1:0]   snoop_addr,
  input  logic [DATA_W-1:0]   snoop_wdata,
  input  logic [ADDR_W-1:0]   sig_begin,
  input  logic [ADDR_W-1:0]   sig_end,
  signature_dumper_if.master  bus,
  output logic                core_halt,
  output logic                done,
  output logic                pass,
  output logic [DATA_W-2:0]   fail_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              halt_q, halt_d;
  logic              pass_q, pass_d;
  logic [DATA_W-2:0] fail_q, fail_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              first_q, first_d;

  logic              halt_evt;
  logic              tmo_hit;
  logic              last_word;
  logic [ADDR_W-1:0] remain;

  assign halt_evt = snoop_we
                  & (snoop_addr == TOHOST_ADDR)
                  & snoop_wdata[0];

  // Remaining bytes; wrap-safe end test that also covers ragged ends.
  assign remain    = sig_end - addr_q;
  assign last_word = (remain <= ADDR_W'(4));

`ifdef SIG_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog counts cycles spent waiting in IDLE.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_IDLE) tmo_cnt_d = tmo_cnt_q + 32'd1;
  end

  assign tmo_hit = (state_q == S_IDLE)
                 & (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  // Next-state and datapath decisions for the dump sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    halt_d  = halt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    data_d  = data_q;
    first_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (halt_evt) begin
          halt_d  = 1'b1;
          pass_d  = (snoop_wdata == DATA_W'(1));
          fail_d  = snoop_wdata[DATA_W-1:1];
          addr_d  = sig_begin;
          state_d = (sig_end <= sig_begin) ? S_DONE : S_READ;
        end else if (tmo_hit) begin
          halt_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = '1;
          state_d = S_DONE;
        end
      end
      S_READ: begin
        first_d = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (first_q) data_d = bus.mem_rdata;
        if (bus.out_ready) begin
          addr_d  = addr_q + ADDR_W'(4);
          state_d = last_word ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      halt_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      halt_q  <= halt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      data_q  <= data_d;
      first_q <= first_d;
    end
  end

  // Read data is only valid in the EMIT entry cycle; later cycles replay the copy.
  assign bus.mem_re    = (state_q == S_READ);
  assign bus.mem_raddr = addr_q;
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_data  = first_q ? bus.mem_rdata : data_q;

  assign core_halt = halt_q;
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign fail_code = fail_q;

endmodule

// File: tb/tb_signature_dumper.sv
// Directed bench for signature_dumper.
// Build with SIG_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=50).
module tb_signature_dumper;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        snoop_we;
  logic [31:0] snoop_addr;
  logic [31:0] snoop_wdata;
  logic [31:0] sig_begin;
  logic [31:0] sig_end;
  logic        core_halt;
  logic        done;
  logic        pass;
  logic [30:0] fail_code;

  signature_dumper_if #(.ADDR_W(32), .DATA_W(32)) bus();

  signature_dumper #(
    .ADDR_W(32),
    .DATA_W(32),
    .TOHOST_ADDR(32'h0000_1000),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .snoop_we(snoop_we),
    .snoop_addr(snoop_addr),
    .snoop_wdata(snoop_wdata),
    .sig_begin(sig_begin),
    .sig_end(sig_end),
    .bus(bus.master),
    .core_halt(core_halt),
    .done(done),
    .pass(pass),
    .fail_code(fail_code)
  );

  localparam logic [31:0] W0 = 32'hA5A5_0001;
  localparam logic [31:0] W1 = 32'hB6B6_0002;
  localparam logic [31:0] W2 = 32'hC7C7_0003;
  localparam logic [31:0] W3 = 32'hD8D8_0004;
  localparam logic [31:0] W4 = 32'h1111_0005;
  localparam logic [31:0] W5 = 32'h2222_0006;
  localparam logic [31:0] W6 = 32'h3333_0007;
  localparam logic [31:0] W7 = 32'h4444_0008;

  // Memory at 0x2000: one-cycle read latency, junk when not reading.
  always @(posedge clk) begin
    if (bus.mem_re) begin
      case (bus.mem_raddr)
        32'h2000: bus.mem_rdata <= W0;
        32'h2004: bus.mem_rdata <= W1;
        32'h2008: bus.mem_rdata <= W2;
        32'h200C: bus.mem_rdata <= W3;
        32'h2010: bus.mem_rdata <= W4;
        32'h2014: bus.mem_rdata <= W5;
        32'h2018: bus.mem_rdata <= W6;
        32'h201C: bus.mem_rdata <= W7;
        default:  bus.mem_rdata <= 32'h0BAD_0BAD;
      endcase
    end else begin
      bus.mem_rdata <= 32'hDEAD_BEEF;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] got[$];
  int cyc;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    snoop_we = 1'b0;
    snoop_addr = '0;
    snoop_wdata = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic snoop_write(input logic [31:0] a, input logic [31:0] d);
    snoop_we = 1'b1;
    snoop_addr = a;
    snoop_wdata = d;
    step();
    snoop_we = 1'b0;
    snoop_addr = '0;
    snoop_wdata = '0;
  endtask

  task automatic run_dump(input int budget, input bit rnd, output int cycles);
    logic        stall;
    logic [31:0] held;
    stall = 1'b0;
    held = '0;
    cycles = 0;
    got.delete();
    while (!done && cycles < budget) begin
      if (stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_data", 64'(bus.out_data), 64'(held));
      end
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      stall = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
      step();
      cycles++;
    end
    chk("dump_budget", 64'(cycles < budget), 64'(1));
  endtask

  task automatic chk_word(input string tag, input int i,
                          input logic [31:0] exp);
    logic [31:0] w;
    w = (i < got.size()) ? got[i] : 32'hXXXX_XXXX;
    chk(tag, 64'(w), 64'(exp));
  endtask

  initial begin
    sig_begin = 32'h2000;
    sig_end = 32'h2010;
    bus.out_ready = 1'b0;

    // Reset values
    do_reset();
    chk("rst_halt", 64'(core_halt), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_fail", 64'(fail_code), 64'(0));
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_re", 64'(bus.mem_re), 64'(0));
    chk("rst_data", 64'(bus.out_data), 64'(0));

    // Test 1: tohost<=1, four words, ready high
    bus.out_ready = 1'b1;
    snoop_write(32'h1000, 32'd1);
    chk("t1_halt", 64'(core_halt), 64'(1));
    chk("t1_re", 64'(bus.mem_re), 64'(1));
    chk("t1_raddr", 64'(bus.mem_raddr), 64'(32'h2000));
    run_dump(100, 1'b0, cyc);
    chk("t1_cycles", 64'(cyc), 64'(8));
    chk("t1_count", 64'(got.size()), 64'(4));
    chk_word("t1_w0", 0, W0);
    chk_word("t1_w1", 1, W1);
    chk_word("t1_w2", 2, W2);
    chk_word("t1_w3", 3, W3);
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_pass", 64'(pass), 64'(1));
    chk("t1_fail", 64'(fail_code), 64'(0));
    // Second halt write is ignored in DONE
    snoop_write(32'h1000, 32'd5);
    step();
    chk("t1_again_pass", 64'(pass), 64'(1));
    chk("t1_again_fail", 64'(fail_code), 64'(0));
    chk("t1_again_valid", 64'(bus.out_valid), 64'(0));
    chk("t1_again_re", 64'(bus.mem_re), 64'(0));
    chk("t1_again_done", 64'(done), 64'(1));

    // Test 2: tohost<=7, ragged end [0x2000,0x2006) -> two words
    do_reset();
    sig_end = 32'h2006;
    bus.out_ready = 1'b1;
    snoop_write(32'h1000, 32'd7);
    run_dump(100, 1'b0, cyc);
    chk("t2_count", 64'(got.size()), 64'(2));
    chk_word("t2_w0", 0, W0);
    chk_word("t2_w1", 1, W1);
    chk("t2_done", 64'(done), 64'(1));
    chk("t2_pass", 64'(pass), 64'(0));
    chk("t2_fail", 64'(fail_code), 64'(3));
    chk("t2_halt", 64'(core_halt), 64'(1));

    // Test 3: eight words under random ready stalls
    do_reset();
    sig_end = 32'h2020;
    snoop_write(32'h1000, 32'd1);
    run_dump(400, 1'b1, cyc);
    chk("t3_count", 64'(got.size()), 64'(8));
    chk_word("t3_w0", 0, W0);
    chk_word("t3_w1", 1, W1);
    chk_word("t3_w2", 2, W2);
    chk_word("t3_w3", 3, W3);
    chk_word("t3_w4", 4, W4);
    chk_word("t3_w5", 5, W5);
    chk_word("t3_w6", 6, W6);
    chk_word("t3_w7", 7, W7);
    chk("t3_done", 64'(done), 64'(1));

    // Test 4: empty signature window
    do_reset();
    sig_end = 32'h2000;
    bus.out_ready = 1'b1;
    snoop_write(32'h1000, 32'd1);
    chk("t4_valid_a", 64'(bus.out_valid), 64'(0));
    chk("t4_re_a", 64'(bus.mem_re), 64'(0));
    step();
    chk("t4_done", 64'(done), 64'(1));
    chk("t4_valid_b", 64'(bus.out_valid), 64'(0));
    chk("t4_halt", 64'(core_halt), 64'(1));
    chk("t4_pass", 64'(pass), 64'(1));

    // Test 5: non-halt writes ignored, then reset mid-EMIT
    do_reset();
    sig_end = 32'h2010;
    snoop_write(32'h1000, 32'd0);
    snoop_write(32'h1004, 32'd1);
    snoop_write(32'h1000, 32'd2);
    repeat (3) step();
    chk("t5_idle_halt", 64'(core_halt), 64'(0));
    chk("t5_idle_re", 64'(bus.mem_re), 64'(0));
    chk("t5_idle_done", 64'(done), 64'(0));
    bus.out_ready = 1'b0;
    snoop_write(32'h1000, 32'd1);
    step();
    chk("t5_emit_valid", 64'(bus.out_valid), 64'(1));
    chk("t5_emit_data", 64'(bus.out_data), 64'(W0));
    step();
    chk("t5_stall_data", 64'(bus.out_data), 64'(W0));
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("t5_rst_halt", 64'(core_halt), 64'(0));
    chk("t5_rst_done", 64'(done), 64'(0));
    chk("t5_rst_re", 64'(bus.mem_re), 64'(0));
    chk("t5_rst_pass", 64'(pass), 64'(0));
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("t5_after_halt", 64'(core_halt), 64'(0));
    chk("t5_after_valid", 64'(bus.out_valid), 64'(0));

`ifdef SIG_TIMEOUT_EN
    // Test 6: watchdog expiry with no halt write
    do_reset();
    bus.out_ready = 1'b1;
    run_dump(200, 1'b0, cyc);
    chk("t6_count", 64'(got.size()), 64'(0));
    chk("t6_done", 64'(done), 64'(1));
    chk("t6_pass", 64'(pass), 64'(0));
    chk("t6_fail", 64'(fail_code), 64'(31'h7FFF_FFFF));
    chk("t6_halt", 64'(core_halt), 64'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
